// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter
//   Round-robin write-port arbiter placed in front of a shared sync_fifo.
//   Each grant is a fixed burst of BL words. A burst starts only when the
//   FIFO has room for all of it. The arbiter keeps its own copy of the FIFO
//   occupancy, built from the pushes it issues and the consumer's pops.
//
// Ports
//   clk, clk7_en, rst_n    clock, 7 MHz enable, sync active-low reset
//   reqN_valid/data        producer N has a word / the word
//   reqN_ready             producer N owns the write port
//   fifo_rd_en             consumer pop strobe (same one the FIFO sees)
//   fifo_wr_en, fifo_in    FIFO write port
//   grant                  one-hot owner during a burst, 00 when idle
//   level                  tracked FIFO occupancy
module fifo_burst_arbiter #(
    parameter  int DW = 16,
    parameter  int FD = 16,
    parameter  int BL = 4,
    localparam int LW = $clog2(FD) + 1,
    localparam int WW = (BL > 1) ? $clog2(BL) : 1
) (
    input  logic          clk,
    input  logic          clk7_en,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic [DW-1:0] req0_data,
    input  logic [DW-1:0] req1_data,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic          fifo_rd_en,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_in,
    output logic [1:0]    grant,
    output logic [LW-1:0] level
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [WW-1:0] wcnt_q,  wcnt_d;
    logic [LW-1:0] level_q, level_d;

    logic in_burst, room, elig0, elig1, own_valid, xfer, pop;

    assign in_burst  = (state_q == S_BURST);
    // level never exceeds FD, so the subtraction cannot wrap
    assign room      = ((LW'(FD) - level_q) >= LW'(BL));
    assign elig0     = req0_valid & room;
    assign elig1     = req1_valid & room;
    assign own_valid = owner_q ? req1_valid : req0_valid;
    assign xfer      = clk7_en & in_burst & own_valid;
    assign pop       = fifo_rd_en & (level_q != '0);

    assign req0_ready = in_burst & ~owner_q;
    assign req1_ready = in_burst &  owner_q;
    assign fifo_wr_en = xfer;
    assign fifo_in    = in_burst ? (owner_q ? req1_data : req0_data) : '0;
    assign grant      = in_burst ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign level      = level_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        level_d = level_q;
        if (clk7_en) begin
            case (state_q)
                S_IDLE: begin
                    if (elig0 | elig1) begin
                        state_d = S_BURST;
                        wcnt_d  = '0;
                        // tie goes to whoever did not own the previous burst
                        owner_d = (elig0 & elig1) ? ~last_q : elig1;
                    end
                end
                S_BURST: begin
                    // grant is held through valid gaps until BL words move
                    if (xfer) begin
                        if (wcnt_q == WW'(BL - 1)) begin
                            wcnt_d  = '0;
                            last_d  = owner_q;
                            state_d = S_IDLE;
                        end else begin
                            wcnt_d = wcnt_q + WW'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (xfer & ~pop)
                level_d = level_q + LW'(1);
            else if (pop & ~xfer)
                level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // requester 0 wins the first tie
            wcnt_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Bench for fifo_burst_arbiter: directed stimulus pushes expected FIFO words
// into a queue; a negedge monitor pops and compares on every fifo_wr_en.
module tb_fifo_burst_arbiter;
    localparam int DW = 16;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          clk7_en, rst_n;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          fifo_rd_en, fifo_wr_en;
    logic [DW-1:0] fifo_in;
    logic [1:0]    grant;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_errors = 0;
    int p0_cnt = 0;
    int p1_cnt = 0;
    logic [DW-1:0] exp_q[$];

    // producers emit an incrementing sequence, advanced on each accepted word
    assign req0_data = 16'h0011 + p0_cnt[15:0];
    assign req1_data = 16'h0201 + p1_cnt[15:0];

    fifo_burst_arbiter #(.DW(16), .FD(16), .BL(4)) dut (
        .clk(clk), .clk7_en(clk7_en), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .fifo_rd_en(fifo_rd_en), .fifo_wr_en(fifo_wr_en),
        .fifo_in(fifo_in), .grant(grant), .level(level)
    );

    always #5 clk = ~clk;

    // monitor
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            n_checks++;
            if (!clk7_en) begin
                n_errors++;
                $display("FAIL wr_en_no_enable: actual clk7_en=%0b required 1 at %0t", clk7_en, $time);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: actual data=%h required no write at %0t", fifo_in, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_in !== e) begin
                    n_errors++;
                    $display("FAIL write_data: actual %h required %h at %0t", fifo_in, e, $time);
                end
            end
            if (req0_ready) p0_cnt++;
            else if (req1_ready) p1_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + DW'(i));
    endtask

    // one enable slot of four clocks: enable in the first, then three idle
    task automatic slot(input logic v_en, input logic v_off);
        clk7_en = 1'b1; req0_valid = v_en;  tick();
        clk7_en = 1'b0; req0_valid = v_off; tick(); tick(); tick();
    endtask

    initial begin
        rst_n = 1'b0; clk7_en = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        fifo_rd_en = 1'b0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_outs", {27'd0, req0_ready, req1_ready, fifo_wr_en, (fifo_in != 0)}, 0);
        rst_n = 1'b1;

        // alternation, consumer idle: 0,1,0,1 then full
        exp_words(16'h0011, 4); exp_words(16'h0201, 4);
        exp_words(16'h0015, 4); exp_words(16'h0205, 4);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1 || t == 11) chk("alt_grant0", 32'(grant), 32'h1);
            if (t == 6 || t == 16) chk("alt_grant1", 32'(grant), 32'h2);
        end
        chk("full_level", 32'(level), 16);
        for (int t = 0; t < 5; t++) tick();
        chk("full_no_grant", 32'(grant), 0);
        chk("full_level_hold", 32'(level), 16);
        chk("alt_all_written", exp_q.size(), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // drain, then pop while empty
        fifo_rd_en = 1'b1;
        for (int t = 0; t < 16; t++) tick();
        chk("drain_level", 32'(level), 0);
        tick();
        chk("pop_empty_level", 32'(level), 0);
        fifo_rd_en = 1'b0;

        // single requester burst
        exp_words(16'h0019, 4);
        req0_valid = 1'b1;
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_level0", 32'(level), 0);
        for (int t = 0; t < 4; t++) tick();
        req0_valid = 1'b0;
        chk("single_level", 32'(level), 4);
        chk("single_grant_end", 32'(grant), 0);
        chk("single_4_words", exp_q.size(), 0);

        // room boundary: fill with three req1 bursts, pop down to 13
        exp_words(16'h0209, 12);
        req1_valid = 1'b1;
        for (int t = 0; t < 15; t++) tick();
        req1_valid = 1'b0;
        chk("fill_level", 32'(level), 16);
        fifo_rd_en = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        fifo_rd_en = 1'b0;
        chk("room_level13", 32'(level), 13);
        req0_valid = 1'b1;
        tick(); tick();
        chk("room_no_grant", 32'(grant), 0);
        exp_words(16'h001D, 4);
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        chk("room_level12", 32'(level), 12);
        chk("room_still_idle", 32'(grant), 0);
        tick();
        chk("room_grant", 32'(grant), 32'h1);
        for (int t = 0; t < 4; t++) tick();
        req0_valid = 1'b0;
        chk("room_level16", 32'(level), 16);

        // simultaneous push and pop at level 5
        fifo_rd_en = 1'b1;
        for (int t = 0; t < 11; t++) tick();
        fifo_rd_en = 1'b0;
        chk("pp_level5", 32'(level), 5);
        exp_words(16'h0215, 4);
        req1_valid = 1'b1;
        tick();
        chk("pp_grant", 32'(grant), 32'h2);
        fifo_rd_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("pp_level_hold", 32'(level), 5);
        end
        fifo_rd_en = 1'b0; req1_valid = 1'b0;
        chk("pp_grant_end", 32'(grant), 0);

        // 1-in-4 enable with valid gaps
        exp_words(16'h0021, 4);
        slot(1'b1, 1'b1); chk("en_grant", 32'(grant), 32'h1); chk("en_lvl_a", 32'(level), 5);
        slot(1'b1, 1'b1); chk("en_lvl_b", 32'(level), 6);
        slot(1'b0, 1'b1); chk("en_gap_grant", 32'(grant), 32'h1); chk("en_lvl_c", 32'(level), 6);
        slot(1'b1, 1'b0); chk("en_lvl_d", 32'(level), 7);
        slot(1'b1, 1'b1); chk("en_lvl_e", 32'(level), 8);
        slot(1'b0, 1'b1); chk("en_gap_grant2", 32'(grant), 32'h1); chk("en_lvl_f", 32'(level), 8);
        slot(1'b1, 1'b0); chk("en_lvl_g", 32'(level), 9); chk("en_grant_end", 32'(grant), 0);
        chk("en_4_words", exp_q.size(), 0);
        clk7_en = 1'b1;

        // reset during the second cycle of a burst
        exp_words(16'h0025, 2);
        req0_valid = 1'b1;
        tick();
        chk("rb_grant", 32'(grant), 32'h1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rb_grant0", 32'(grant), 0);
        chk("rb_level0", 32'(level), 0);
        chk("rb_outs", {27'd0, req0_ready, req1_ready, fifo_wr_en, (fifo_in != 0)}, 0);
        chk("rb_words", exp_q.size(), 0);
        rst_n = 1'b1;
        exp_words(16'h0027, 4);
        req1_valid = 1'b1;
        tick();
        chk("rb_tie_to_0", 32'(grant), 32'h1);
        for (int t = 0; t < 4; t++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rb_level4", 32'(level), 4);
        tick(); tick();
        chk("end_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_burst_arbiter.md
# fifo_burst_arbiter

Two-requester write-side arbiter for a single shared `sync_fifo`. It grants the FIFO write port to one producer at a time for a fixed-length burst, alternating between producers round-robin. It starts a burst only when the FIFO has room for the whole burst. The block sits between two producers (e.g. host register port and DMA engine) and the FIFO. It tracks FIFO occupancy itself from the pushes it issues and the consumer's pops.

## Interface
Parameters:
- `DW`, 16, data width of FIFO and requester data.
- `FD`, 16, depth of the attached FIFO; must equal the FIFO's `FD`.
- `BL`, 4, words per burst; power of two, 1 ≤ BL ≤ FD.

Ports:
- `clk`  in  1  system clock.
- `clk7_en`  in  1  7 MHz clock enable; all state advances only when high.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  requester N has a word to write.
- `req0_data`, `req1_data`  in  DW  requester N write data.
- `req0_ready`, `req1_ready`  out  1  requester N owns the write port this cycle.
- `fifo_rd_en`  in  1  consumer pop strobe, the same signal that drives the FIFO.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_in`  out  DW  FIFO write data.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `level`  out  clog2(FD)+1  tracked FIFO occupancy.

## Operation
- State machine has two states: IDLE and BURST.
  - Registers: `owner` (1 bit), `last` (1 bit, owner of the previous burst), `wcnt` (clog2(BL) bits, 0 when BL = 1), `level`.
- Eligibility: requester N is eligible when `reqN_valid` = 1 and `FD - level >= BL`. Compare at `clog2(FD)+1` bits with no underflow.
- IDLE, on a `clk7_en` cycle:
  - If exactly one requester is eligible, go to BURST with `owner` = that requester.
  - If both are eligible, `owner` = `~last`.
  - If none is eligible, stay in IDLE.
- BURST:
  - `reqN_ready` = (N == `owner`); the other ready is 0.
  - Transfer condition: `xfer` = `clk7_en & ready & valid` of the owner.
  - On `xfer`, `wcnt` increments. On the BL-th transfer, `wcnt` wraps to 0, `last` ← `owner`, and the state returns to IDLE.
  - The owner may deassert `valid` mid-burst. The grant is held, with no timeout, until BL words have transferred.
- `fifo_wr_en` = `xfer` (combinational).
- `fifo_in` = owner's data while in BURST, else 0.
- `grant` = one-hot of `owner` in BURST, else 00.
- Level tracking, updated on `clk7_en` cycles only:
  - `pop` = `fifo_rd_en & (level != 0)`.
  - push & !pop → +1; pop & !push → −1; both or neither → unchanged.
  - This matches the FIFO's own counter.
- The room check at burst start guarantees that `fifo_wr_en` never hits a full FIFO. Pops during a burst only add room.
- `fifo_rd_en` asserted while `level` = 0 is ignored.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge, regardless of `clk7_en`):
  - State IDLE, `owner` = 0, `last` = 1 (so requester 0 wins the first tie), `wcnt` = 0, `level` = 0.
  - All outputs 0: `req*_ready`, `fifo_wr_en`, `fifo_in`, `grant`.
- Reset mid-burst abandons the burst. The words already written stay in the FIFO. The FIFO must be reset together with this block, otherwise `level` desynchronises.
- Arbitration latency: an eligible request seen at enable cycle k gives `ready` high from the `clk` edge after k. The first transfer is possible at enable cycle k+1.
- Burst throughput: one word per enable cycle while `valid` is held.
- Burst end: IDLE lasts at least one enable cycle between bursts. Minimum gap is one enable slot.
- Cycles with `clk7_en` = 0:
  - No transfer occurs, even if ready & valid.
  - `level`, `wcnt` and state hold.
  - `ready` may stay high.
- `level` reflects pushes and pops one `clk` edge after the enable cycle in which they occur.

## Test plan
- Single requester, BL = 4, FD = 16, empty FIFO, `req0_valid` held with data 0x11..0x14:
  - `grant` = 01 one enable cycle after the request.
  - Exactly 4 `fifo_wr_en` pulses.
  - `level` = 4, then `grant` = 00.
- Both requesters valid continuously, consumer idle:
  - Bursts alternate 0, 1, 0, 1.
  - After 4 bursts, `level` = 16 and no grant is issued.
  - No `fifo_wr_en` occurs while full.
- Room boundary: `level` = 13, BL = 4:
  - No grant.
  - One `fifo_rd_en` pulse → `level` = 12, and a grant follows on the next enable cycle.
- Simultaneous push and pop on an enable cycle with `level` = 5 → `level` stays 5. Pop with `level` = 0 → `level` stays 0.
- `clk7_en` toggling 1-in-4 during a burst with valid gaps:
  - Transfers occur only on enable cycles.
  - Exactly BL words are written.
  - The grant is held across the gaps.
- `rst_n` low on cycle 2 of a burst:
  - The next cycle shows all outputs 0, IDLE, `level` = 0.
  - The next tie goes to requester 0.
